// File: rtl/traffic_light_sequencer_if.sv
// rtl/traffic_light_sequencer_if.sv - Sequencer control/status bundle; ped_req exists only with PED_REQ_EN.
interface traffic_light_sequencer_if #(parameter int TW = 7);
  logic          tick;
  logic          set_mode;
  logic [TW-1:0] time_green;
  logic [TW-1:0] time_yellow;
  logic [TW-1:0] time_red;
  logic [2:0]    alert_time;
`ifdef PED_REQ_EN
  logic          ped_req;
`endif
  logic [2:0]    light;
  logic [TW-1:0] remain;
  logic [3:0]    remain_tens;
  logic [3:0]    remain_ones;
  logic          phase_done;
  logic          fault;

`ifdef PED_REQ_EN
  modport master (
    output tick, set_mode, time_green, time_yellow, time_red, alert_time, ped_req,
    input  light, remain, remain_tens, remain_ones, phase_done, fault
  );
  modport slave (
    input  tick, set_mode, time_green, time_yellow, time_red, alert_time, ped_req,
    output light, remain, remain_tens, remain_ones, phase_done, fault
  );
`else
  modport master (
    output tick, set_mode, time_green, time_yellow, time_red, alert_time,
    input  light, remain, remain_tens, remain_ones, phase_done, fault
  );
  modport slave (
    input  tick, set_mode, time_green, time_yellow, time_red, alert_time,
    output light, remain, remain_tens, remain_ones, phase_done, fault
  );
`endif
endinterface

// File: rtl/traffic_light_sequencer.sv
// rtl/traffic_light_sequencer.sv - Green/yellow/red countdown sequencer with blinking-yellow fault mode.
// Optional pedestrian green shortening is enabled by the PED_REQ_EN macro.
module traffic_light_sequencer #(
  parameter int TW = 7
`ifdef PED_REQ_EN
  , parameter logic [TW-1:0] PED_GREEN = 7'd5
`endif
) (
  input logic                      clk,
  input logic                      rst_n,
  traffic_light_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_SETUP, S_GREEN, S_YELLOW, S_RED, S_FAULT} state_t;

  state_t        r_state;
  logic [2:0]    r_light;
  logic [TW-1:0] r_remain;
  logic          r_phase_done;
  logic          r_fault;
  logic [TW-1:0] r_sh_green;
  logic [TW-1:0] r_sh_yellow;
  logic [TW-1:0] r_sh_red;
  logic          w_bcd_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_SETUP;
      r_light      <= 3'b000;
      r_remain     <= '0;
      r_phase_done <= 1'b0;
      r_fault      <= 1'b0;
      r_sh_green   <= '0;
      r_sh_yellow  <= '0;
      r_sh_red     <= '0;
    end else begin
      r_phase_done <= 1'b0;
      if (bus.set_mode) begin
        r_state  <= S_SETUP;
        r_light  <= 3'b000;
        r_remain <= '0;
        r_fault  <= 1'b0;
      end else begin
        case (r_state)
          S_SETUP: begin
            if (bus.alert_time == 3'b000) begin
              r_state     <= S_GREEN;
              r_sh_green  <= bus.time_green;
              r_sh_yellow <= bus.time_yellow;
              r_sh_red    <= bus.time_red;
              r_remain    <= bus.time_green;
              r_light     <= 3'b001;
            end else begin
              r_state  <= S_FAULT;
              r_light  <= 3'b010;
              r_fault  <= 1'b1;
              r_remain <= '0;
            end
          end
          S_GREEN: begin
`ifdef PED_REQ_EN
            if (bus.ped_req && (r_remain > PED_GREEN)) begin
              r_remain <= PED_GREEN;
            end else
`endif
            if (bus.tick) begin
              // remain==0 is treated like 1 so a zero shadow advances rather than wrapping
              if (r_remain > TW'(1)) begin
                r_remain <= r_remain - TW'(1);
              end else begin
                r_state      <= S_YELLOW;
                r_remain     <= r_sh_yellow;
                r_light      <= 3'b010;
                r_phase_done <= 1'b1;
              end
            end
          end
          S_YELLOW: begin
            if (bus.tick) begin
              if (r_remain > TW'(1)) begin
                r_remain <= r_remain - TW'(1);
              end else begin
                r_state      <= S_RED;
                r_remain     <= r_sh_red;
                r_light      <= 3'b100;
                r_phase_done <= 1'b1;
              end
            end
          end
          S_RED: begin
            if (bus.tick) begin
              if (r_remain > TW'(1)) begin
                r_remain <= r_remain - TW'(1);
              end else begin
                r_state      <= S_GREEN;
                r_remain     <= r_sh_green;
                r_light      <= 3'b001;
                r_phase_done <= 1'b1;
              end
            end
          end
          S_FAULT: begin
            if (bus.tick) begin
              r_light <= r_light ^ 3'b010;
            end
          end
          default: begin
            r_state  <= S_SETUP;
            r_light  <= 3'b000;
            r_remain <= '0;
            r_fault  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w_bcd_ovf       = (r_remain > TW'(99));
  assign bus.light       = r_light;
  assign bus.remain      = r_remain;
  assign bus.phase_done  = r_phase_done;
  assign bus.fault       = r_fault;
  assign bus.remain_tens = w_bcd_ovf ? 4'hF : 4'(r_remain / TW'(10));
  assign bus.remain_ones = w_bcd_ovf ? 4'hF : 4'(r_remain % TW'(10));
endmodule
